// File: rtl/alu_op_sequencer.sv
// Clocked command/response wrapper around the combinational ALU: registers the
// operands, waits for the ALU to settle, captures the result and keeps an accumulator.
module alu_op_sequencer #(
  parameter int DATA_W        = 32,
  parameter int OUT_W         = 64,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_opcode,
  input  logic [DATA_W-1:0] cmd_operand,
  input  logic [DATA_W-1:0] cmd_operand_b,
  input  logic              cmd_use_acc,
  input  logic              acc_clear,
  output logic [DATA_W-1:0] alu_input1,
  output logic [DATA_W-1:0] alu_input2,
  output logic [3:0]        alu_opcode,
  input  logic [OUT_W-1:0]  alu_output1,
  input  logic [1:0]        alu_error,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_W-1:0]  res_data,
  output logic [1:0]        res_error,
  output logic [OUT_W-1:0]  acc,
  output logic [1:0]        sticky_error,
  output logic              busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] in1_q, in1_d;
  logic [DATA_W-1:0] in2_q, in2_d;
  logic [3:0]        op_q, op_d;
  logic [OUT_W-1:0]  res_data_q, res_data_d;
  logic [1:0]        res_err_q, res_err_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [1:0]        sticky_q, sticky_d;
  logic [DATA_W-1:0] acc_eff_lo;

  // A clear in the accept cycle must already be visible to the feedback path.
  assign acc_eff_lo = acc_clear ? '0 : acc_q[DATA_W-1:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    op_d       = op_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    acc_d      = acc_q;
    sticky_d   = sticky_q;

    case (state_q)
      IDLE: begin
        if (acc_clear) begin
          acc_d    = '0;
          sticky_d = '0;
        end
        if (cmd_valid) begin
          // Illegal opcodes take a one-cycle SETTLE pass so they report at N+1.
          if (cmd_opcode < 4'd12) begin
            op_d      = cmd_opcode;
            in2_d     = cmd_operand;
            in1_d     = cmd_use_acc ? acc_eff_lo : cmd_operand_b;
            cnt_d     = SETTLE_INIT;
            illegal_d = 1'b0;
          end else begin
            cnt_d     = 4'd1;
            illegal_d = 1'b1;
          end
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          if (illegal_q) begin
            res_data_d = '0;
            res_err_d  = 2'b11;
            sticky_d   = sticky_q | 2'b11;
          end else begin
            res_data_d = alu_output1;
            res_err_d  = alu_error;
            sticky_d   = sticky_q | alu_error;
            if (alu_error == 2'b00) acc_d = alu_output1;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      illegal_q  <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
      op_q       <= '0;
      res_data_q <= '0;
      res_err_q  <= '0;
      acc_q      <= '0;
      sticky_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      op_q       <= op_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      acc_q      <= acc_d;
      sticky_q   <= sticky_d;
    end
  end

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign res_valid    = (state_q == RESP);
  assign alu_input1   = in1_q;
  assign alu_input2   = in2_q;
  assign alu_opcode   = op_q;
  assign res_data     = res_data_q;
  assign res_error    = res_err_q;
  assign acc          = acc_q;
  assign sticky_error = sticky_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: a behavioural ALU stub feeds two instances (settle 1 and 4),
// and a command-level model predicts every response, accumulator and sticky error.
module tb_alu_op_sequencer;

  localparam int SETTLE1 = 1;
  localparam int SETTLE4 = 4;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid, cmd_valid4;
  logic [3:0]  cmd_opcode;
  logic [31:0] cmd_operand, cmd_operand_b;
  logic        cmd_use_acc, acc_clear;
  logic        res_ready, res_ready4;

  logic        cmd_ready, res_valid, busy;
  logic [31:0] alu_input1, alu_input2;
  logic [3:0]  alu_opcode;
  logic [63:0] alu_output1, res_data, acc;
  logic [1:0]  alu_error, res_error, sticky_error;

  logic        cmd_ready4, res_valid4, busy4;
  logic [31:0] alu_input1_4, alu_input2_4;
  logic [3:0]  alu_opcode4;
  logic [63:0] alu_output1_4, res_data4, acc4;
  logic [1:0]  alu_error4, res_error4, sticky_error4;

  int tests = 0;
  int fails = 0;

  logic [63:0] accM;
  logic [1:0]  stickyM;
  logic [31:0] in1M, in2M;
  logic [3:0]  opM;

  // Stand-in for the ALU breadboard; the result is {error, 64-bit value}.
  function automatic logic [65:0] aluModel(input logic [3:0] op, input logic [31:0] a1,
                                           input logic [31:0] a2);
    logic [63:0] r;
    logic [1:0]  e;
    logic [31:0] s;
    r = '0;
    e = '0;
    case (op)
      4'd0: begin s = a1 + a2; r = {32'd0, s}; e[0] = (a1[31] == a2[31]) && (s[31] != a1[31]); end
      4'd1: begin s = a1 - a2; r = {32'd0, s}; e[0] = (a1[31] != a2[31]) && (s[31] != a1[31]); end
      4'd2: if (a1 == 0) e = 2'b10; else r = {32'd0, a2 / a1};
      4'd3: if (a1 == 0) e = 2'b10; else r = {32'd0, a2 % a1};
      4'd4: r = 64'(a1) * 64'(a2);
      4'd5: r = {32'd0, a1 & a2};
      4'd6: r = {32'd0, a1 | a2};
      4'd7: r = {32'd0, a1 ^ a2};
      4'd8: r = {32'd0, ~a1};
      4'd9: r = {32'd0, a1 << a2[4:0]};
      4'd10: r = {32'd0, a1 >> a2[4:0]};
      4'd11: r = {63'd0, (a1 < a2)};
      default: e = 2'b11;
    endcase
    return {e, r};
  endfunction

  assign {alu_error, alu_output1}    = aluModel(alu_opcode, alu_input1, alu_input2);
  assign {alu_error4, alu_output1_4} = aluModel(alu_opcode4, alu_input1_4, alu_input2_4);

  alu_op_sequencer #(.DATA_W(32), .OUT_W(64), .SETTLE_CYCLES(SETTLE1)) dut1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand), .cmd_operand_b(cmd_operand_b),
    .cmd_use_acc(cmd_use_acc), .acc_clear(acc_clear), .alu_input1(alu_input1),
    .alu_input2(alu_input2), .alu_opcode(alu_opcode), .alu_output1(alu_output1),
    .alu_error(alu_error), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_error(res_error), .acc(acc),
    .sticky_error(sticky_error), .busy(busy)
  );

  alu_op_sequencer #(.DATA_W(32), .OUT_W(64), .SETTLE_CYCLES(SETTLE4)) dut4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4),
    .cmd_opcode(cmd_opcode), .cmd_operand(cmd_operand), .cmd_operand_b(cmd_operand_b),
    .cmd_use_acc(cmd_use_acc), .acc_clear(acc_clear), .alu_input1(alu_input1_4),
    .alu_input2(alu_input2_4), .alu_opcode(alu_opcode4), .alu_output1(alu_output1_4),
    .alu_error(alu_error4), .res_valid(res_valid4), .res_ready(res_ready4),
    .res_data(res_data4), .res_error(res_error4), .acc(acc4),
    .sticky_error(sticky_error4), .busy(busy4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full command on the settle-1 instance, optionally with a stalled consumer
  // while cmd_valid keeps presenting junk that must not be accepted.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] operand,
                               input logic [31:0] operandB, input logic useAcc,
                               input logic clr, input int stall, input logic keepValid);
    logic [63:0] expRes;
    logic [1:0]  expErr;
    logic [63:0] heldData;
    int          expLat;
    int          lat;
    @(negedge clk);
    checkOutput("cmd_ready_idle", cmd_ready, 1);
    cmd_opcode    = op;
    cmd_operand   = operand;
    cmd_operand_b = operandB;
    cmd_use_acc   = useAcc;
    acc_clear     = clr;
    cmd_valid     = 1'b1;
    res_ready     = (stall == 0);

    if (clr) begin
      accM    = '0;
      stickyM = '0;
    end
    if (op < 4'd12) begin
      in1M = useAcc ? accM[31:0] : operandB;
      in2M = operand;
      opM  = op;
      {expErr, expRes} = aluModel(opM, in1M, in2M);
      expLat = SETTLE1;
      if (expErr == 2'b00) accM = expRes;
    end else begin
      expRes = '0;
      expErr = 2'b11;
      expLat = 1;
    end
    stickyM = stickyM | expErr;

    @(posedge clk);
    @(negedge clk);
    cmd_valid   = keepValid;
    acc_clear   = 1'b0;
    cmd_operand = $urandom;
    cmd_opcode  = 4'($urandom_range(0, 11));
    checkOutput("alu_input1", alu_input1, in1M);
    checkOutput("alu_input2", alu_input2, in2M);
    checkOutput("alu_opcode", alu_opcode, opM);
    checkOutput("busy", busy, 1);

    lat = 0;
    while (res_valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("res_data", res_data, expRes);
    checkOutput("res_error", res_error, expErr);
    checkOutput("acc", acc, accM);
    checkOutput("sticky_error", sticky_error, stickyM);

    heldData = expRes;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checkOutput("stall_res_valid", res_valid, 1);
      checkOutput("stall_res_data", res_data, heldData);
      checkOutput("stall_cmd_ready", cmd_ready, 0);
      checkOutput("stall_alu_input2", alu_input2, in2M);
    end
    res_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_hs_res_valid", res_valid, 0);
    checkOutput("post_hs_cmd_ready", cmd_ready, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic clearAcc();
    @(negedge clk);
    acc_clear = 1'b1;
    @(negedge clk);
    acc_clear = 1'b0;
    accM    = '0;
    stickyM = '0;
    checkOutput("clear_acc", acc, 0);
    checkOutput("clear_sticky", sticky_error, 0);
  endtask

  initial begin
    int lat;
    rst_n = 1'b1;
    cmd_valid = 0; cmd_valid4 = 0; cmd_opcode = 0; cmd_operand = 0; cmd_operand_b = 0;
    cmd_use_acc = 0; acc_clear = 0; res_ready = 1; res_ready4 = 1;
    accM = 0; stickyM = 0; in1M = 0; in2M = 0; opM = 0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rst_cmd_ready", cmd_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_res_valid", res_valid, 0);
    checkOutput("rst_acc", acc, 0);
    checkOutput("rst_sticky", sticky_error, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Settle-4 instance: a normal add, then reset two cycles into SETTLE.
    @(negedge clk);
    cmd_opcode = 4'd0; cmd_operand = 32'd5; cmd_operand_b = 32'd7; cmd_use_acc = 0;
    cmd_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid4 = 1'b0;
    lat = 0;
    while (res_valid4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("s4_latency", lat, SETTLE4);
    checkOutput("s4_res_data", res_data4, 64'd12);
    checkOutput("s4_acc", acc4, 64'd12);
    @(negedge clk);
    checkOutput("s4_res_valid_drop", res_valid4, 0);

    cmd_opcode = 4'd0; cmd_operand = 32'd1; cmd_operand_b = 32'd2;
    cmd_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid4 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("s4_rst_res_valid", res_valid4, 0);
    checkOutput("s4_rst_busy", busy4, 0);
    checkOutput("s4_rst_acc", acc4, 0);
    checkOutput("s4_rst_alu_input1", alu_input1_4, 0);
    checkOutput("s4_rst_alu_input2", alu_input2_4, 0);
    checkOutput("s4_rst_res_data", res_data4, 0);
    checkOutput("s4_rst_cmd_ready", cmd_ready4, 1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    accM = 0; stickyM = 0; in1M = 0; in2M = 0; opM = 0;

    @(negedge clk);
    cmd_opcode = 4'd4; cmd_operand = 32'd1000; cmd_operand_b = 32'd3000;
    cmd_valid4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid4 = 1'b0;
    lat = 0;
    while (res_valid4 !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("s4_after_rst_latency", lat, SETTLE4);
    checkOutput("s4_after_rst_res", res_data4, 64'd3000000);
    checkOutput("s4_after_rst_acc", acc4, 64'd3000000);

    // Directed sequence on the settle-1 instance.
    applyStimulus(4'd0, 32'd5, 32'd7, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("add_acc_is_12", acc, 64'd12);
    applyStimulus(4'd0, 32'd3, 32'd0, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("accum_acc_is_15", acc, 64'd15);
    applyStimulus(4'd2, 32'd4, 32'd0, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("div0_acc_kept", acc, 64'd15);
    checkOutput("div0_sticky", sticky_error, 2'b10);
    clearAcc();
    applyStimulus(4'd0, 32'd5, 32'd7, 1'b0, 1'b0, 0, 1'b0);
    applyStimulus(4'd0, 32'd3, 32'd9, 1'b1, 1'b1, 0, 1'b0);
    checkOutput("clr_accept_res", res_data, 64'd3);
    applyStimulus(4'd13, 32'd77, 32'd88, 1'b0, 1'b0, 0, 1'b0);
    checkOutput("illegal_sticky", sticky_error, 2'b11);
    applyStimulus(4'd1, 32'd10, 32'd50, 1'b0, 1'b0, 5, 1'b1);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] opB;
      opB = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 9) == 0) clearAcc();
      applyStimulus(4'($urandom_range(0, 15)), $urandom, opB, 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
